multicycle_control: RTL and testbench

- Multi-cycle main control FSM that replaces the single-cycle control decoder in the next-generation core.
- Sequences one instruction over 3–5 states and shares a single memory port for instruction and data.
- Handshakes with variable-latency memory via mem_ready, with a parametrised wait-timeout watchdog.
- Drives all datapath mux selects and write strobes; ALU function decode stays in the existing ALU control block, fed by alu_op.

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences one instruction over 3-5 states, sharing
// a single memory port, with a wait-timeout watchdog on every memory handshake.
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1,
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_J     = 6'h02,
    parameter logic [5:0]  OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_FAULT     = 4'd12
    } state_t;

    localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(MAX_WAIT - 1) : '0;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                mem_state_s;
    logic                timeout_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and wait counter; a late mem_ready always beats the timeout.
    always_comb begin
        mem_state_s = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
        timeout_s   = TIMEOUT_EN && mem_state_s && !mem_ready && (wait_q == WAIT_LAST);
        state_d     = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : (timeout_s ? S_FAULT : S_FETCH);
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)                state_d = S_EXECUTE;
                else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else if (opcode == OP_ADDI)                 state_d = S_ADDI_EXEC;
                else                                        state_d = S_FAULT;
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FAULT;
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : (timeout_s ? S_FAULT : S_MEM_READ);
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : (timeout_s ? S_FAULT : S_MEM_WRITE);
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_FAULT;
        endcase
        if (mem_state_s && !mem_ready && !timeout_s) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        fault         = 1'b0;
        state_o       = 4'd0;
        if (!rst) begin
            state_o = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:    alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_FAULT:     fault = 1'b1;
                default:     fault = 1'b1;
            endcase
        end else begin
            state_o = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed literal scenarios plus a
// randomized run compared every cycle against an instruction-level reference model.
module tb_multicycle_control;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, fault;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_o;

    typedef struct packed {
        logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic instr_done, fault;
        logic [3:0] state;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_done, fault, state_o};

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .fault(fault),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference model: current step of the instruction plus the steps still to come.
    int m_cur   = 0;
    int m_stall = 0;
    int m_q[$];

    function automatic outs_t exp_out(input int s, input logic rdy, input logic r);
        outs_t o;
        o = '0;
        if (r) return o;
        o.state = 4'(s);
        case (s)
            0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; end
            5:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy; end
            6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1; end
            8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                      o.pc_source = 2'b01; o.instr_done = 1'b1; end
            9:  begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; end
            10: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            11: begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
            default: o.fault = 1'b1;
        endcase
        return o;
    endfunction

    task automatic model_step();
        if (m_cur == 12) return;
        if ((m_cur == 0 || m_cur == 3 || m_cur == 5) && !mem_ready) begin
            m_stall++;
            if (m_stall == MAXW) begin
                m_cur   = 12;
                m_stall = 0;
            end
            return;
        end
        m_stall = 0;
        if (m_cur == 0) begin
            m_cur = 1;
        end else if (m_cur == 1) begin
            m_q.delete();
            case (opcode)
                6'h00:   begin m_q.push_back(6); m_q.push_back(7); end
                6'h23:   begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
                6'h2B:   begin m_q.push_back(2); m_q.push_back(5); end
                6'h04:   m_q.push_back(8);
                6'h02:   m_q.push_back(9);
                6'h08:   begin m_q.push_back(10); m_q.push_back(11); end
                default: m_q.push_back(12);
            endcase
            m_cur = m_q.pop_front();
        end else if (m_q.size() == 0) begin
            m_cur = 0;
        end else begin
            m_cur = m_q.pop_front();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cur   = 0;
                m_stall = 0;
                m_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        outs_t e;
        e = exp_out(m_cur, mem_ready, rst);
        n_tests++;
        if (dut_o !== e) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t model_state=%0d actual=%h required=%h",
                     $time, m_cur, dut_o, e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_seq(input logic [5:0] op, input logic rdy);
        rst = 1'b1;
        opcode = op;
        mem_ready = rdy;
        #1;
        chk("reset_outputs", int'(dut_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0: return 6'h00;
            1: return 6'h23;
            2: return 6'h2B;
            3: return 6'h04;
            4: return 6'h02;
            5: return 6'h08;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        int st_r[5] = '{0, 1, 6, 7, 0};
        int st_l[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        bit rd_l[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        int dones;
        int fault_cyc;

        // R-type with memory always ready
        rst_seq(6'h00, 1'b1);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rtype_state", state_o, st_r[i]);
            dones += int'(instr_done);
            if (i == 0) chk("rtype_fetch_strobes", {ir_write, pc_write}, 3);
            if (i == 3) chk("rtype_wb", {reg_write, reg_dst}, 3);
            adv();
        end
        chk("rtype_done_pulses", dones, 1);

        // LW with three not-ready cycles in MEM_READ
        rst_seq(6'h23, 1'b1);
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd_l[i];
            @(negedge clk);
            chk("lw_state", state_o, st_l[i]);
            if (st_l[i] == 3) chk("lw_read_req", {mem_read, i_or_d}, 3);
            if (i == 7) chk("lw_mem_to_reg", mem_to_reg, 1);
            chk("lw_no_fault", fault, 0);
            adv();
        end

        // FETCH timeout, sticky fault, reset clears it
        rst_seq(6'h00, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("timeout_state", state_o, (i < 4) ? 0 : 12);
            chk("timeout_ir_write", ir_write, 0);
            chk("timeout_fault", fault, (i < 4) ? 0 : 1);
            adv();
        end
        rst = 1'b1;
        #1;
        chk("fault_cleared_by_rst", fault, 0);

        // mem_ready on the last allowed wait cycle wins over the timeout
        rst_seq(6'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            chk("late_ready_state", state_o, (i < 4) ? 0 : 1);
            chk("late_ready_fault", fault, 0);
            adv();
        end

        // Illegal opcode, then BEQ
        rst_seq(6'h3F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("illegal_state", state_o, (i == 2) ? 12 : i);
            if (i == 2) chk("illegal_fault", fault, 1);
            adv();
        end
        rst_seq(6'h04, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("beq_state", state_o, (i == 2) ? 8 : i);
            if (i == 2) chk("beq_outputs", {pc_write_cond, alu_op, pc_source}, 7'b1_01_01);
            adv();
        end

        // Asynchronous reset in the middle of a store
        rst_seq(6'h2B, 1'b1);
        for (int i = 0; i < 3; i++) adv();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_write_req", {state_o, mem_write}, {4'd5, 1'b1});
        #2 rst = 1'b1;
        #1;
        chk("sw_abort_outputs", {mem_write, instr_done, state_o}, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("sw_restart_state", state_o, 0);
        chk("sw_restart_done", instr_done, 0);
        adv();

        // Randomized traffic against the model
        rst_seq(pick_op(), 1'b1);
        fault_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst) begin
                rst = 1'b0;
            end else if (m_cur == 12 && fault_cyc >= 3) begin
                rst = 1'b1;
                fault_cyc = 0;
            end
            if (m_cur == 12) fault_cyc++;
            if (m_cur == 0) opcode = pick_op();
            mem_ready = ($urandom_range(0, 9) < 7);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

endmodule
